decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage of the 5-stage pipeline; sits between IF/ID and EX.
//  Decodes InstrD into control signals and extends its immediate.
//  Reads two operands from an internal 32x32 register file; WB writes that file.
//  Registers everything into the ID/EX pipeline register (1-cycle latency).
// PARAMETERS
//  XLEN  32  datapath width (fixed; listed for documentation)
// PORTS
//  clk          in   1   rising-edge clock (single clock domain)
//  reset        in   1   asynchronous, active-high reset
//  InstrD       in   32  instruction in ID
//  PCD          in   32  PC of InstrD
//  PCPlus4D     in   32  PCD+4
//  RegWriteW    in   1   WB register write enable
//  RdW          in   5   WB destination register
//  ResultW      in   32  WB write data
//  RegWriteE    out  1   registered controls; decoded from InstrD in the previous cycle
//  MemWriteE    out  1
//  JumpE        out  1
//  BranchE      out  1
//  ALUSrcE      out  1
//  ResultSrcE   out  2
//  ALUControlE  out  3
//  RdE          out  5   registered InstrD[11:7]
//  RD1E, RD2E   out  32  registered regfile reads of rs1=InstrD[19:15] and rs2=InstrD[24:20]
//  PCE, PCPlus4E, ImmExtE  out 32  registered PCD, PCPlus4D, ImmExt
// BEHAVIOUR
//  - reset asserted: all outputs and all 32 registers become 0 immediately.
//  - ID/EX register: plain load every rising edge; no stall or flush.
//  - Regfile: write on posedge when RegWriteW && RdW!=0. x0 always reads 0.
//  - Regfile read bypass: a read of RdW in the same cycle returns ResultW.
//  - Main decoder, op=InstrD[6:0] (RegW ImmSrc ALUSrc MemW ResSrc Br ALUOp Jmp):
//      lw   0000011: 1 00 1 0 01 0 00 0
//      sw   0100011: 0 01 1 1 00 0 00 0
//      R    0110011: 1 00 0 0 00 0 10 0
//      beq  1100011: 0 10 0 0 00 1 01 0
//      I    0010011: 1 00 1 0 00 0 10 0
//      jal  1101111: 1 11 0 0 10 0 00 1
//      other opcodes: all controls 0.
//  - ALU decoder; f3=InstrD[14:12], f7b5=InstrD[30], op5=InstrD[5]:
//      ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub)
//      ALUOp 10, f3 000: 001 (sub) if op5&f7b5, else 000 (add)
//      ALUOp 10, f3 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and)
//      any other ALUOp/f3 combination -> 000
//  - Extend by ImmSrc (sign bit i[31]):
//      00 I: {20{i31}, i[31:20]}
//      01 S: {20{i31}, i[31:25], i[11:7]}
//      10 B: {20{i31}, i[7], i[30:25], i[11:8], 0}
//      11 J: {12{i31}, i[19:12], i[20], i[30:21], 0}
//  - Reset deasserting mid-stream: first capture on the next posedge; no partial state.
// STRUCTURE
//  - Shared package: opcode constants, ALUControl encodings, ImmSrc/ResultSrc encodings.
//  - Decoding and immediate extension are combinational; the regfile is a local array.
//  - One natural sub-module: decode_idex_reg (ID/EX pipeline register with async reset).
// TESTING
//  - reset=1 mid-run -> every output 0 at once; after release, an add to x0 reads RD1E=RD2E=0.
//  - WB writes x1=5, x2=7; InstrD=0x002081B3 (add x3,x1,x2) -> next edge:
//    RD1E=5, RD2E=7, RdE=3, RegWriteE=1, ALUControlE=000, ALUSrcE=0.
//  - InstrD=0x40208233 (sub x4,x1,x2) -> ALUControlE=001, RdE=4.
//  - InstrD=0xFFC12283 (lw x5,-4(x2)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
//  - InstrD=0x00612423 (sw) -> ImmExtE=8, MemWriteE=1, RegWriteE=0.
//  - InstrD=0x010000EF (jal x1,16), PCD=0x10 -> ImmExtE=16, JumpE=1, ResultSrcE=10,
//    PCE=0x10, PCPlus4E=0x14.
//  - WB writes x0=9 -> read of x0 stays 0.
//  - Same-cycle write/read of x1 -> RD1E equals ResultW (bypass).

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared encodings and types for the RV32I decode stage
//
// Purpose : opcode constants, ALUControl / ImmSrc / ResultSrc encodings, the
//           ID/EX payload struct and the immediate-extension helper.
// Ports   : none (package).
package decode_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctl_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      ALUOP_ADD  = 2'b00,
      ALUOP_SUB  = 2'b01,
      ALUOP_FUNC = 2'b10
   } alu_op_e;

   // Everything the EX stage receives, registered as one unit.
   typedef struct packed {
      logic            reg_write;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic [1:0]      result_src;
      logic [2:0]      alu_control;
      logic [4:0]      rd;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] imm_ext;
   } idex_t;

   function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] i, input imm_src_e src);
      case (src)
         IMM_I:   return {{20{i[31]}}, i[31:20]};
         IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         default: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

endpackage

// File: rtl/decode_idex_reg.sv
// rtl/decode_idex_reg.sv - ID/EX pipeline register
//
// Purpose : loads the decoded payload every rising edge; no stall or flush.
// Ports   : clk_i  clock
//           rst_i  asynchronous active-high reset, clears the payload
//           d_i    payload from decode
//           q_o    registered payload to EX
module decode_idex_reg
   import decode_stage_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  idex_t d_i,
   output idex_t q_o
);

   idex_t q_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: control decode, immediate extend, regfile read
//
// Purpose : decodes InstrD, extends its immediate, reads rs1/rs2 from the
//           internal 32x32 register file (written by WB) and registers the
//           result into ID/EX with one cycle of latency.
// Ports   : clk, reset (async, active-high)
//           InstrD, PCD, PCPlus4D           instruction and PCs in ID
//           RegWriteW, RdW, ResultW         write-back port of the register file
//           RegWriteE..ALUControlE, RdE     registered controls
//           RD1E, RD2E, PCE, PCPlus4E, ImmExtE  registered datapath values
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   output logic        RegWriteE,
   output logic        MemWriteE,
   output logic        JumpE,
   output logic        BranchE,
   output logic        ALUSrcE,
   output logic [1:0]  ResultSrcE,
   output logic [2:0]  ALUControlE,
   output logic [4:0]  RdE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E,
   output logic [31:0] ImmExtE
);

   logic [31:0] rf_q [32];

   logic        reg_write, alu_src, mem_write, branch, jump;
   imm_src_e    imm_src;
   result_src_e result_src;
   alu_op_e     alu_op;
   alu_ctl_e    alu_ctl;
   idex_t       idex_d, idex_q;

   wire [6:0] op   = InstrD[6:0];
   wire [2:0] f3   = InstrD[14:12];
   wire [4:0] rs1  = InstrD[19:15];
   wire [4:0] rs2  = InstrD[24:20];
   wire       f7b5 = InstrD[30];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (RegWriteW && RdW != 5'd0) begin
         rf_q[RdW] <= ResultW;
      end
   end

   // x0 is hard-wired; a register being written this cycle returns the
   // incoming WB data so ID never sees a stale value.
   function automatic logic [31:0] rf_read(input logic [4:0] a);
      if (a == 5'd0)                  return '0;
      else if (RegWriteW && a == RdW) return ResultW;
      else                            return rf_q[a];
   endfunction

   always_comb begin
      reg_write  = 1'b0;
      imm_src    = IMM_I;
      alu_src    = 1'b0;
      mem_write  = 1'b0;
      result_src = RES_ALU;
      branch     = 1'b0;
      alu_op     = ALUOP_ADD;
      jump       = 1'b0;
      case (op)
         OP_LW:  begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; end
         OP_SW:  begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
         OP_R:   begin reg_write = 1'b1; alu_op = ALUOP_FUNC; end
         OP_BEQ: begin imm_src = IMM_B; branch = 1'b1; alu_op = ALUOP_SUB; end
         OP_I:   begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_FUNC; end
         OP_JAL: begin reg_write = 1'b1; imm_src = IMM_J; result_src = RES_PC4; jump = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      alu_ctl = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_FUNC: begin
            case (f3)
               // Only R-type (op5=1) with funct7[5] set is a subtract; addi never is.
               3'b000:  alu_ctl = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctl = ALU_SLT;
               3'b110:  alu_ctl = ALU_OR;
               3'b111:  alu_ctl = ALU_AND;
               default: alu_ctl = ALU_ADD;
            endcase
         end
         default: alu_ctl = ALU_ADD;
      endcase
   end

   always_comb begin
      idex_d             = '0;
      idex_d.reg_write   = reg_write;
      idex_d.mem_write   = mem_write;
      idex_d.jump        = jump;
      idex_d.branch      = branch;
      idex_d.alu_src     = alu_src;
      idex_d.result_src  = result_src;
      idex_d.alu_control = alu_ctl;
      idex_d.rd          = InstrD[11:7];
      idex_d.rd1         = rf_read(rs1);
      idex_d.rd2         = rf_read(rs2);
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.imm_ext     = imm_extend(InstrD, imm_src);
   end

   decode_idex_reg u_idex_reg (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (idex_d),
      .q_o   (idex_q)
   );

   assign RegWriteE   = idex_q.reg_write;
   assign MemWriteE   = idex_q.mem_write;
   assign JumpE       = idex_q.jump;
   assign BranchE     = idex_q.branch;
   assign ALUSrcE     = idex_q.alu_src;
   assign ResultSrcE  = idex_q.result_src;
   assign ALUControlE = idex_q.alu_control;
   assign RdE         = idex_q.rd;
   assign RD1E        = idex_q.rd1;
   assign RD2E        = idex_q.rd2;
   assign PCE         = idex_q.pc;
   assign PCPlus4E    = idex_q.pc_plus4;
   assign ImmExtE     = idex_q.imm_ext;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

   typedef struct packed {
      logic        regw;
      logic        memw;
      logic        jump;
      logic        branch;
      logic        alusrc;
      logic [1:0]  ressrc;
      logic [2:0]  aluctl;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] imm;
   } out_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0;
   logic        RegWriteW = 1'b0;
   logic [4:0]  RdW = '0;
   logic [31:0] ResultW = '0;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [4:0]  RdE;
   logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;

   out_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE)
   );

   function automatic out_t sample();
      return '{RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RdE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE};
   endfunction

   function automatic out_t mk(input logic regw, memw, jump, branch, alusrc,
                               input logic [1:0] ressrc, input logic [2:0] aluctl,
                               input logic [4:0] rd, input logic [31:0] rd1, rd2, pc, imm);
      return '{regw, memw, jump, branch, alusrc, ressrc, aluctl, rd, rd1, rd2, pc, pc + 32'd4, imm};
   endfunction

   // Called at a negedge: drive one instruction (plus an optional WB write),
   // record what EX must see, and return at the negedge after the capture edge.
   task automatic issue(input logic [31:0] instr, pc, input logic wbw, input logic [4:0] wbrd,
                        input logic [31:0] wbres, input out_t exp);
      InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
      RegWriteW = wbw; RdW = wbrd; ResultW = wbres;
      sb.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      RegWriteW = 1'b0; RdW = '0; ResultW = '0;
   endtask

   task automatic test_reset();
      out_t got;
      #1;
      got = sample();
      n_total++;
      if (got !== out_t'(0)) $display("FAIL reset_state: got %h required 0", got);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_wb_setup();
      out_t got, exp;
      issue(32'h0, 32'h0, 1'b1, 5'd1, 32'd5, mk(0,0,0,0,0,2'b00,3'b000,5'd0,0,0,32'h0,0));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL wb_x1: got %h required %h", got, exp); else n_pass++;
      issue(32'h0, 32'h4, 1'b1, 5'd2, 32'd7, mk(0,0,0,0,0,2'b00,3'b000,5'd0,0,0,32'h4,0));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL wb_x2: got %h required %h", got, exp); else n_pass++;
   endtask

   task automatic test_decode_table();
      vec_t tbl[$];
      out_t got, exp;
      tbl.push_back('{"add",   32'h002081B3, 32'h100, mk(1,0,0,0,0,2'b00,3'b000,5'd3, 5,7,32'h100,32'd2)});
      tbl.push_back('{"sub",   32'h40208233, 32'h104, mk(1,0,0,0,0,2'b00,3'b001,5'd4, 5,7,32'h104,32'h402)});
      tbl.push_back('{"lw",    32'hFFC12283, 32'h108, mk(1,0,0,0,1,2'b01,3'b000,5'd5, 7,0,32'h108,32'hFFFFFFFC)});
      tbl.push_back('{"sw",    32'h00612423, 32'h10C, mk(0,1,0,0,1,2'b00,3'b000,5'd8, 7,0,32'h10C,32'd8)});
      tbl.push_back('{"beq",   32'h00208463, 32'h110, mk(0,0,0,1,0,2'b00,3'b001,5'd8, 5,7,32'h110,32'd8)});
      tbl.push_back('{"jal",   32'h010000EF, 32'h010, mk(1,0,1,0,0,2'b10,3'b000,5'd1, 0,0,32'h010,32'd16)});
      tbl.push_back('{"ori",   32'hFFF0E393, 32'h114, mk(1,0,0,0,1,2'b00,3'b011,5'd7, 5,0,32'h114,32'hFFFFFFFF)});
      tbl.push_back('{"slti",  32'h00312413, 32'h118, mk(1,0,0,0,1,2'b00,3'b101,5'd8, 7,0,32'h118,32'd3)});
      tbl.push_back('{"other", 32'hFFFFFFFF, 32'h11C, mk(0,0,0,0,0,2'b00,3'b000,5'd31,0,0,32'h11C,32'hFFFFFFFF)});
      foreach (tbl[k]) begin
         issue(tbl[k].instr, tbl[k].pc, 1'b0, 5'd0, 32'd0, tbl[k].exp);
         got = sample(); exp = sb.pop_front(); n_total++;
         if (got !== exp) $display("FAIL %s: got %h required %h", tbl[k].name, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_x0();
      out_t got, exp;
      issue(32'h000001B3, 32'h200, 1'b1, 5'd0, 32'd9, mk(1,0,0,0,0,2'b00,3'b000,5'd3,0,0,32'h200,0));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL x0_write_bypass: got %h required %h", got, exp); else n_pass++;
      issue(32'h000001B3, 32'h204, 1'b0, 5'd0, 32'd0, mk(1,0,0,0,0,2'b00,3'b000,5'd3,0,0,32'h204,0));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL x0_stays_zero: got %h required %h", got, exp); else n_pass++;
   endtask

   task automatic test_bypass();
      out_t got, exp;
      issue(32'h002081B3, 32'h300, 1'b1, 5'd1, 32'h1234, mk(1,0,0,0,0,2'b00,3'b000,5'd3,32'h1234,7,32'h300,2));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL bypass_rs1: got %h required %h", got, exp); else n_pass++;
      issue(32'h002081B3, 32'h304, 1'b0, 5'd0, 32'd0, mk(1,0,0,0,0,2'b00,3'b000,5'd3,32'h1234,7,32'h304,2));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL bypass_stored: got %h required %h", got, exp); else n_pass++;
   endtask

   task automatic test_back_to_back();
      out_t got, exp;
      logic [31:0] vals [4];
      for (int i = 0; i < 4; i++) begin
         vals[i] = $urandom;
         issue(32'h0, 32'h400 + 32'(i*4), 1'b1, 5'(11 + i), vals[i],
               mk(0,0,0,0,0,2'b00,3'b000,5'd0,0,0,32'h400 + 32'(i*4),0));
         got = sample(); exp = sb.pop_front(); n_total++;
         if (got !== exp) $display("FAIL b2b_write%0d: got %h required %h", i, got, exp); else n_pass++;
      end
      // add x3,x11,x12
      issue(32'h00C581B3, 32'h420, 1'b0, 5'd0, 32'd0,
            mk(1,0,0,0,0,2'b00,3'b000,5'd3,vals[0],vals[1],32'h420,32'd12));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL b2b_read: got %h required %h", got, exp); else n_pass++;
   endtask

   task automatic test_reset_midrun();
      out_t got, exp;
      issue(32'h002081B3, 32'h500, 1'b0, 5'd0, 32'd0, mk(1,0,0,0,0,2'b00,3'b000,5'd3,32'h1234,7,32'h500,2));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL pre_reset: got %h required %h", got, exp); else n_pass++;
      reset = 1'b1;
      #1;
      got = sample(); n_total++;
      if (got !== out_t'(0)) $display("FAIL reset_async: got %h required 0", got); else n_pass++;
      @(posedge clk);
      #1;
      got = sample(); n_total++;
      if (got !== out_t'(0)) $display("FAIL reset_held: got %h required 0", got); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      issue(32'h002081B3, 32'h600, 1'b0, 5'd0, 32'd0, mk(1,0,0,0,0,2'b00,3'b000,5'd3,0,0,32'h600,2));
      got = sample(); exp = sb.pop_front(); n_total++;
      if (got !== exp) $display("FAIL post_reset_regfile: got %h required %h", got, exp); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_wb_setup();
      test_decode_table();
      test_x0();
      test_bypass();
      test_back_to_back();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
